// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges two in-order issue lanes and a queued long-latency
// result stream onto the register file's two write ports in program order.
module wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int LQ_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        laneA_valid_i,
    input  logic [ADDR_WIDTH-1:0]       laneA_rd_i,
    input  logic [DATA_WIDTH-1:0]       laneA_data_i,
    input  logic                        laneB_valid_i,
    input  logic [ADDR_WIDTH-1:0]       laneB_rd_i,
    input  logic [DATA_WIDTH-1:0]       laneB_data_i,
    input  logic                        lat_valid_i,
    input  logic [ADDR_WIDTH-1:0]       lat_rd_i,
    input  logic [DATA_WIDTH-1:0]       lat_data_i,
    output logic                        lat_ready_o,
    output logic [1:0]                  we_o,
    output logic [ADDR_WIDTH-1:0]       ad3A_o,
    output logic [DATA_WIDTH-1:0]       wd3A_o,
    output logic [ADDR_WIDTH-1:0]       ad3B_o,
    output logic [DATA_WIDTH-1:0]       wd3B_o,
    output logic [$clog2(LQ_DEPTH):0]   lq_count_o
);
    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] q_rd   [LQ_DEPTH];
    logic [DATA_WIDTH-1:0] q_data [LQ_DEPTH];
    logic [LQ_DEPTH-1:0]   q_live;
    logic [PW-1:0]         head, tail;
    logic [CW-1:0]         occ;

    logic                  a_wr, b_wr, enq, enq_live;
    logic [LQ_DEPTH-1:0]   kill;
    logic                  dr_a, dr_b;
    logic [PW-1:0]         dr_a_idx, dr_b_idx;
    logic [CW-1:0]         pop;
    logic                  used_a, used_b, stop, took;
    logic [ADDR_WIDTH-1:0] took_rd;
    logic [PW-1:0]         idx;

    assign b_wr = laneB_valid_i && (laneB_rd_i != '0);
    assign a_wr = laneA_valid_i && (laneA_rd_i != '0) && !(b_wr && (laneB_rd_i == laneA_rd_i));

    assign lat_ready_o = (occ < CW'(LQ_DEPTH));
    assign enq         = lat_valid_i && lat_ready_o;
    assign enq_live    = (lat_rd_i != '0)
                         && !(a_wr && (lat_rd_i == laneA_rd_i))
                         && !(b_wr && (lat_rd_i == laneB_rd_i));

    // A lane write this cycle is younger than anything queued for the same rd.
    always_comb begin
        for (int i = 0; i < LQ_DEPTH; i++)
            kill[i] = (a_wr && (q_rd[i] == laneA_rd_i)) || (b_wr && (q_rd[i] == laneB_rd_i));
    end

    always_comb begin
        lq_count_o = '0;
        for (int i = 0; i < LQ_DEPTH; i++)
            if ((CW'(i) < occ) && q_live[head + PW'(i)])
                lq_count_o = lq_count_o + CW'(1);
    end

    // Walk from head: dead entries pop for free; live ones take A then B.
    // A second live entry with the same rd waits a cycle so the two writes stay ordered.
    always_comb begin
        used_a   = a_wr;
        used_b   = b_wr;
        stop     = 1'b0;
        took     = 1'b0;
        took_rd  = '0;
        idx      = '0;
        dr_a     = 1'b0;
        dr_b     = 1'b0;
        dr_a_idx = '0;
        dr_b_idx = '0;
        pop      = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            idx = head + PW'(i);
            if (!stop && (CW'(i) < occ)) begin
                if (!q_live[idx] || kill[idx]) begin
                    pop = pop + CW'(1);
                end else if (took && (q_rd[idx] == took_rd)) begin
                    stop = 1'b1;
                end else if (!used_a) begin
                    used_a   = 1'b1;
                    dr_a     = 1'b1;
                    dr_a_idx = idx;
                    took     = 1'b1;
                    took_rd  = q_rd[idx];
                    pop      = pop + CW'(1);
                end else if (!used_b) begin
                    used_b   = 1'b1;
                    dr_b     = 1'b1;
                    dr_b_idx = idx;
                    took     = 1'b1;
                    took_rd  = q_rd[idx];
                    pop      = pop + CW'(1);
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head   <= '0;
            tail   <= '0;
            occ    <= '0;
            q_live <= '0;
            we_o   <= '0;
            ad3A_o <= '0;
            wd3A_o <= '0;
            ad3B_o <= '0;
            wd3B_o <= '0;
        end else begin
            q_live <= q_live & ~kill;
            if (enq) begin
                q_rd[tail]   <= lat_rd_i;
                q_data[tail] <= lat_data_i;
                q_live[tail] <= enq_live;
            end
            head <= head + pop[PW-1:0];
            tail <= tail + PW'(enq);
            occ  <= occ - pop + CW'(enq);
            we_o <= {a_wr || dr_a, b_wr || dr_b};
            if (a_wr) begin
                ad3A_o <= laneA_rd_i;
                wd3A_o <= laneA_data_i;
            end else if (dr_a) begin
                ad3A_o <= q_rd[dr_a_idx];
                wd3A_o <= q_data[dr_a_idx];
            end
            if (b_wr) begin
                ad3B_o <= laneB_rd_i;
                wd3B_o <= laneB_data_i;
            end else if (dr_b) begin
                ad3B_o <= q_rd[dr_b_idx];
                wd3B_o <= q_data[dr_b_idx];
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, then random traffic against a
// queue-based reference model of the writeback rules.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        laneA_valid_i, laneB_valid_i, lat_valid_i;
    logic [4:0]  laneA_rd_i, laneB_rd_i, lat_rd_i;
    logic [31:0] laneA_data_i, laneB_data_i, lat_data_i;
    logic        lat_ready_o;
    logic [1:0]  we_o;
    logic [4:0]  ad3A_o, ad3B_o;
    logic [31:0] wd3A_o, wd3B_o;
    logic [2:0]  lq_count_o;

    wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .LQ_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .laneA_valid_i(laneA_valid_i), .laneA_rd_i(laneA_rd_i), .laneA_data_i(laneA_data_i),
        .laneB_valid_i(laneB_valid_i), .laneB_rd_i(laneB_rd_i), .laneB_data_i(laneB_data_i),
        .lat_valid_i(lat_valid_i), .lat_rd_i(lat_rd_i), .lat_data_i(lat_data_i),
        .lat_ready_o(lat_ready_o), .we_o(we_o),
        .ad3A_o(ad3A_o), .wd3A_o(wd3A_o), .ad3B_o(ad3B_o), .wd3B_o(wd3B_o),
        .lq_count_o(lq_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic av; logic [4:0] ard; logic [31:0] adat;
        logic bv; logic [4:0] brd; logic [31:0] bdat;
        logic lv; logic [4:0] lrd; logic [31:0] ldat;
        logic [1:0] we; logic [4:0] xa; logic [31:0] xwa; logic [4:0] xb; logic [31:0] xwb;
        logic [2:0] cnt; logic rdy;
    } vec_t;

    typedef struct { logic [4:0] rd; logic [31:0] data; bit live; } ent_t;

    vec_t        tbl[$];
    ent_t        mq[$];
    logic [31:0] rf[32];
    int          checks = 0;
    int          errors = 0;

    logic [1:0]  exp_we;
    logic [4:0]  exp_xa, exp_xb;
    logic [31:0] exp_wa, exp_wb;
    logic [2:0]  exp_cnt;
    logic        exp_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic row(input int rst, input int av, input int ard, input int adat,
                       input int bv, input int brd, input int bdat,
                       input int lv, input int lrd, input int ldat,
                       input int we, input int xa, input int xwa, input int xb, input int xwb,
                       input int cnt, input int rdy);
        vec_t v;
        v.rst = 1'(rst); v.av = 1'(av); v.ard = 5'(ard); v.adat = 32'(adat);
        v.bv = 1'(bv); v.brd = 5'(brd); v.bdat = 32'(bdat);
        v.lv = 1'(lv); v.lrd = 5'(lrd); v.ldat = 32'(ldat);
        v.we = 2'(we); v.xa = 5'(xa); v.xwa = 32'(xwa); v.xb = 5'(xb); v.xwb = 32'(xwb);
        v.cnt = 3'(cnt); v.rdy = 1'(rdy);
        tbl.push_back(v);
    endtask

    // Reference: lane writes win, kill older queued copies, queued live results
    // fill idle ports oldest-first; same-rd results never share a cycle.
    task automatic model_step();
        bit aw, bw, ua, ub, took, rdy;
        logic [4:0] trd;
        int live_n;
        if (!reset) begin
            mq.delete();
            exp_we = 2'b00; exp_xa = '0; exp_xb = '0; exp_wa = '0; exp_wb = '0;
            exp_cnt = '0; exp_rdy = 1'b1;
            return;
        end
        rdy = (mq.size() < 4);
        bw  = laneB_valid_i && (laneB_rd_i != 0);
        aw  = laneA_valid_i && (laneA_rd_i != 0) && !(bw && laneA_rd_i == laneB_rd_i);
        exp_we = 2'b00;
        if (aw) begin exp_we[1] = 1'b1; exp_xa = laneA_rd_i; exp_wa = laneA_data_i; end
        if (bw) begin exp_we[0] = 1'b1; exp_xb = laneB_rd_i; exp_wb = laneB_data_i; end
        foreach (mq[i])
            if ((aw && mq[i].rd == laneA_rd_i) || (bw && mq[i].rd == laneB_rd_i)) mq[i].live = 0;
        ua = aw; ub = bw; took = 0; trd = '0;
        while (mq.size() > 0) begin
            if (!mq[0].live) begin mq.delete(0); continue; end
            if (took && mq[0].rd == trd) break;
            if (!ua) begin
                ua = 1; exp_we[1] = 1'b1; exp_xa = mq[0].rd; exp_wa = mq[0].data;
            end else if (!ub) begin
                ub = 1; exp_we[0] = 1'b1; exp_xb = mq[0].rd; exp_wb = mq[0].data;
            end else break;
            took = 1; trd = mq[0].rd;
            mq.delete(0);
        end
        if (lat_valid_i && rdy) begin
            ent_t e;
            e.rd = lat_rd_i; e.data = lat_data_i;
            e.live = (lat_rd_i != 0) && !(aw && lat_rd_i == laneA_rd_i) && !(bw && lat_rd_i == laneB_rd_i);
            mq.push_back(e);
        end
        live_n = 0;
        foreach (mq[i]) if (mq[i].live) live_n++;
        exp_cnt = 3'(live_n);
        exp_rdy = (mq.size() < 4);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        if (we_o[1]) rf[ad3A_o] = wd3A_o;
        if (we_o[0]) rf[ad3B_o] = wd3B_o;
    endtask

    task automatic apply(input vec_t v);
        reset = !v.rst;
        laneA_valid_i = v.av; laneA_rd_i = v.ard; laneA_data_i = v.adat;
        laneB_valid_i = v.bv; laneB_rd_i = v.brd; laneB_data_i = v.bdat;
        lat_valid_i = v.lv; lat_rd_i = v.lrd; lat_data_i = v.ldat;
    endtask

    initial begin
        foreach (rf[i]) rf[i] = '0;
        reset = 1'b0;
        laneA_valid_i = 0; laneB_valid_i = 0; lat_valid_i = 0;
        laneA_rd_i = '0; laneB_rd_i = '0; lat_rd_i = '0;
        laneA_data_i = '0; laneB_data_i = '0; lat_data_i = '0;

        // rst av ard adat bv brd bdat lv lrd ldat | we xa xwa xb xwb cnt rdy
        row(1, 1, 5, 'h11, 1, 6, 'h66, 0, 0, 0,      0, 0, 0, 0, 0, 0, 1);
        row(1, 1, 5, 'h11, 1, 6, 'h66, 0, 0, 0,      0, 0, 0, 0, 0, 0, 1);
        row(0, 1, 5, 'h11, 0, 0, 0, 0, 0, 0,         2, 5, 'h11, 0, 0, 0, 1);
        row(0, 1, 7, 'hA, 1, 7, 'hB, 0, 0, 0,        1, 0, 0, 7, 'hB, 0, 1);
        row(0, 1, 1, 'h1, 1, 2, 'h2, 1, 3, 'h33,     3, 1, 'h1, 2, 'h2, 1, 1);
        row(0, 1, 1, 'h10, 1, 2, 'h20, 1, 4, 'h44,   3, 1, 'h10, 2, 'h20, 2, 1);
        row(0, 1, 8, 'h80, 0, 0, 0, 0, 0, 0,         3, 8, 'h80, 3, 'h33, 1, 1);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,            2, 4, 'h44, 0, 0, 0, 1);
        row(0, 1, 1, 'h1, 1, 2, 'h2, 1, 9, 'h99,     3, 1, 'h1, 2, 'h2, 1, 1);
        row(0, 0, 0, 0, 1, 9, 'h55, 0, 0, 0,         1, 0, 0, 9, 'h55, 0, 1);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 1);
        row(0, 1, 1, 'h1, 1, 2, 'h2, 1, 10, 'hA0,    3, 1, 'h1, 2, 'h2, 1, 1);
        row(0, 1, 1, 'h1, 1, 2, 'h2, 1, 11, 'hB0,    3, 1, 'h1, 2, 'h2, 2, 1);
        row(0, 1, 1, 'h1, 1, 2, 'h2, 1, 12, 'hC0,    3, 1, 'h1, 2, 'h2, 3, 1);
        row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 1);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 1);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++)
            row(0, 1, 1, 'h1, 1, 2, 'h2, 1, 13 + k, 'hD0 + k, 3, 1, 'h1, 2, 'h2, k + 1, (k == 3) ? 0 : 1);
        row(0, 1, 1, 'h1, 1, 2, 'h2, 1, 17, 'hE0,    3, 1, 'h1, 2, 'h2, 4, 0);
        row(0, 0, 0, 0, 1, 2, 'h2, 1, 17, 'hE0,      3, 13, 'hD0, 2, 'h2, 3, 1);
        row(0, 1, 1, 'h1, 1, 2, 'h2, 1, 17, 'hE0,    3, 1, 'h1, 2, 'h2, 4, 0);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,            3, 14, 'hD1, 15, 'hD2, 2, 1);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,            3, 16, 'hD3, 17, 'hE0, 0, 1);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 1);

        foreach (tbl[n]) begin
            apply(tbl[n]);
            cycle();
            chk($sformatf("vec%0d.we", n), 32'(we_o), 32'(tbl[n].we));
            chk($sformatf("vec%0d.cnt", n), 32'(lq_count_o), 32'(tbl[n].cnt));
            chk($sformatf("vec%0d.rdy", n), 32'(lat_ready_o), 32'(tbl[n].rdy));
            if (tbl[n].we[1] || tbl[n].rst) begin
                chk($sformatf("vec%0d.adA", n), 32'(ad3A_o), 32'(tbl[n].xa));
                chk($sformatf("vec%0d.wdA", n), wd3A_o, tbl[n].xwa);
            end
            if (tbl[n].we[0] || tbl[n].rst) begin
                chk($sformatf("vec%0d.adB", n), 32'(ad3B_o), 32'(tbl[n].xb));
                chk($sformatf("vec%0d.wdB", n), wd3B_o, tbl[n].xwb);
            end
        end
        chk("stale_kill.rf9", rf[9], 32'h55);

        for (int c = 0; c < 3000; c++) begin
            reset         = (c == 0 || $urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            laneA_valid_i = ($urandom_range(0, 9) < 5);
            laneA_rd_i    = 5'($urandom_range(0, 7));
            laneA_data_i  = $urandom;
            laneB_valid_i = ($urandom_range(0, 9) < 5);
            laneB_rd_i    = 5'($urandom_range(0, 7));
            laneB_data_i  = $urandom;
            lat_valid_i   = ($urandom_range(0, 9) < 6);
            lat_rd_i      = 5'($urandom_range(0, 7));
            lat_data_i    = $urandom;
            cycle();
            chk("rnd.we", 32'(we_o), 32'(exp_we));
            chk("rnd.cnt", 32'(lq_count_o), 32'(exp_cnt));
            chk("rnd.rdy", 32'(lat_ready_o), 32'(exp_rdy));
            chk("rnd.same_addr", 32'(we_o == 2'b11 && ad3A_o == ad3B_o), 32'(0));
            if (exp_we[1]) begin
                chk("rnd.adA", 32'(ad3A_o), 32'(exp_xa));
                chk("rnd.wdA", wd3A_o, exp_wa);
            end
            if (exp_we[0]) begin
                chk("rnd.adB", 32'(ad3B_o), 32'(exp_xb));
                chk("rnd.wdB", wd3B_o, exp_wb);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
